// File: rtl/prog_loader_pkg.sv
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared types and constants for the program loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_loader_pkg;

  localparam int c_len_w  = 16;
  localparam int c_byte_w = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/prog_loader_byte_packer.sv
// ============================================================================
// Module      : byte_packer
// Description : Shifts little-endian stream bytes into a DATA_W word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_packer
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [c_byte_w-1:0] in_byte,
  output logic [DATA_W-1:0]   word,
  output logic                last
);

  localparam int BYTES = DATA_W / c_byte_w;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(BYTES - 1);

  logic [DATA_W-1:0] r_word;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] w_shift;

  // New byte enters at the top so the first byte ends up in bits [7:0].
  generate
    if (BYTES == 1) begin : g_single
      assign w_shift = in_byte;
    end else begin : g_multi
      assign w_shift = {in_byte, r_word[DATA_W-1:c_byte_w]};
    end
  endgenerate

  assign word = w_shift;
  assign last = en && (r_idx == c_last_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (clr) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (en) begin
      r_word <= w_shift;
      r_idx  <= last ? '0 : r_idx + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module      : prog_loader
// Description : Streams a length/data/checksum frame into imem, gating core reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int MEM_DEPTH = 60,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [c_byte_w-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                core_rst,
  output logic                done,
  output logic                error,
  output logic [c_len_w-1:0]  word_cnt
);

  localparam logic [c_len_w-1:0] c_depth = c_len_w'(MEM_DEPTH);

  loader_state_t r_state;
  loader_state_t w_next;

  logic [c_byte_w-1:0] r_len_lo;
  logic [c_len_w-1:0]  r_len;
  logic [c_byte_w-1:0] r_xor;
  logic [c_len_w-1:0]  r_word_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_accept;
  logic                w_start_ok;
  logic                w_data_en;
  logic                w_last;
  logic [DATA_W-1:0]   w_word;
  logic [c_len_w-1:0]  w_len_full;
  logic [c_len_w-1:0]  w_cnt_inc;

  assign in_ready   = (r_state == LEN0) || (r_state == LEN1) ||
                      (r_state == DATA) || (r_state == CSUM);
  assign w_accept   = in_valid && in_ready;
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));
  assign w_data_en  = w_accept && (r_state == DATA);
  assign w_len_full = {in_data, r_len_lo};
  assign w_cnt_inc  = r_word_cnt + 16'd1;

  byte_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_start_ok),
    .en      (w_data_en),
    .in_byte (in_data),
    .word    (w_word),
    .last    (w_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERROR: if (start) w_next = LEN0;
      LEN0: if (w_accept) w_next = LEN1;
      LEN1: begin
        if (w_accept) begin
          if (w_len_full > c_depth)   w_next = ERROR;
          else if (w_len_full == '0)  w_next = CSUM;
          else                        w_next = DATA;
        end
      end
      DATA: if (w_last && (w_cnt_inc == r_len)) w_next = CSUM;
      CSUM: if (w_accept) w_next = (in_data == r_xor) ? DONE : ERROR;
      default: w_next = IDLE;
    endcase
  end

  // Write strobe, address and data are registered so imem sees them stable for one full cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len_lo   <= '0;
      r_len      <= '0;
      r_xor      <= '0;
      r_word_cnt <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start_ok) begin
        r_word_cnt <= '0;
        r_xor      <= '0;
      end
      if (w_accept && (r_state == LEN0)) r_len_lo <= in_data;
      if (w_accept && (r_state == LEN1)) r_len    <= w_len_full;
      if (w_data_en) begin
        r_xor <= r_xor ^ in_data;
        if (w_last) begin
          r_we       <= 1'b1;
          r_addr     <= r_word_cnt[ADDR_W-1:0];
          r_wdata    <= w_word;
          r_word_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign word_cnt  = r_word_cnt;
  assign done      = (r_state == DONE);
  assign error     = (r_state == ERROR);
  assign core_rst  = (r_state != DONE);

endmodule

`default_nettype wire
